// File: rtl/l2_request_arbiter_pkg.sv
// Shared types for the L2 request arbiter.
// Request opcodes, source ids and the registered L2 request packet.
package l2_request_arbiter_pkg;

  typedef enum logic [1:0] {
    L2_LOAD,
    L2_LOAD_INSN,
    L2_STORE,
    L2_FLUSH
  } l2_op_t;

  typedef logic [1:0] l2_req_source_t;

  localparam l2_req_source_t SRC_ICACHE = 2'd0;
  localparam l2_req_source_t SRC_DCACHE = 2'd1;
  localparam l2_req_source_t SRC_SQ     = 2'd2;

  typedef struct packed {
    l2_op_t         op;
    l2_req_source_t source;
    logic [1:0]     idx;
    logic           synchronized;
    logic [31:0]    addr;
    logic [63:0]    mask;
    logic [511:0]   data;
  } l2_req_packet_t;

endpackage

// File: rtl/l2_request_arbiter_rr_arbiter3.sv
// Three-way rotating-priority arbiter.
// Scans upward from the source after the last winner.
module rr_arbiter3
  import l2_request_arbiter_pkg::*;
(
  input  logic [2:0]     i_request,
  input  l2_req_source_t i_last_grant,
  output logic [2:0]     o_grant
);

  always_comb begin
    o_grant = 3'b000;
    unique case (i_last_grant)
      2'd0: begin
        if (i_request[1])      o_grant = 3'b010;
        else if (i_request[2]) o_grant = 3'b100;
        else if (i_request[0]) o_grant = 3'b001;
      end
      2'd1: begin
        if (i_request[2])      o_grant = 3'b100;
        else if (i_request[0]) o_grant = 3'b001;
        else if (i_request[1]) o_grant = 3'b010;
      end
      default: begin
        if (i_request[0])      o_grant = 3'b001;
        else if (i_request[1]) o_grant = 3'b010;
        else if (i_request[2]) o_grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares the single L2 request port between icache, dcache and store queue.
// Round-robin grant, registered output stage, credit-limited issue.
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_CREDITS = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           icache_req_ready,
  input  logic [31:0]    icache_req_addr,
  input  logic [1:0]     icache_req_idx,
  output logic           icache_req_ack,
  input  logic           dcache_req_ready,
  input  logic [31:0]    dcache_req_addr,
  input  logic [1:0]     dcache_req_idx,
  output logic           dcache_req_ack,
  input  logic           sq_dequeue_ready,
  input  logic [31:0]    sq_dequeue_addr,
  input  logic [1:0]     sq_dequeue_idx,
  input  logic [63:0]    sq_dequeue_mask,
  input  logic [511:0]   sq_dequeue_data,
  input  logic           sq_dequeue_synchronized,
  input  logic           sq_dequeue_flush,
  output logic           sq_dequeue_ack,
  output logic           l2_req_valid,
  output l2_req_packet_t l2_req,
  input  logic           l2_ready,
  input  logic           l2_credit_return
);

  localparam int CW = $clog2(NUM_CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_CREDITS);

  logic [CW-1:0]  r_credits;
  l2_req_source_t r_last_grant;
  logic           r_valid;
  l2_req_packet_t r_pkt;

  logic           w_slot_open;
  logic [2:0]     w_request;
  logic [2:0]     w_grant;
  logic           w_load;
  l2_req_source_t w_src;
  l2_req_packet_t w_pkt;

  // Slot test uses the registered count, so a return only helps next cycle.
  assign w_slot_open = (!r_valid || l2_ready) && (r_credits != '0);
  assign w_request   = {sq_dequeue_ready, dcache_req_ready, icache_req_ready}
                     & {3{w_slot_open}};

  rr_arbiter3 u_rr (
    .i_request    (w_request),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_load = |w_grant;
  assign w_src  = w_grant[2] ? SRC_SQ :
                  w_grant[1] ? SRC_DCACHE : SRC_ICACHE;

  assign icache_req_ack = w_grant[0];
  assign dcache_req_ack = w_grant[1];
  assign sq_dequeue_ack = w_grant[2];

  always_comb begin
    w_pkt = '0;
    w_pkt.source = w_src;
    unique case (1'b1)
      w_grant[0]: begin
        w_pkt.op   = L2_LOAD_INSN;
        w_pkt.idx  = icache_req_idx;
        w_pkt.addr = icache_req_addr;
      end
      w_grant[1]: begin
        w_pkt.op   = L2_LOAD;
        w_pkt.idx  = dcache_req_idx;
        w_pkt.addr = dcache_req_addr;
      end
      w_grant[2]: begin
        w_pkt.op           = sq_dequeue_flush ? L2_FLUSH : L2_STORE;
        w_pkt.idx          = sq_dequeue_idx;
        w_pkt.addr         = sq_dequeue_addr;
        w_pkt.mask         = sq_dequeue_mask;
        w_pkt.data         = sq_dequeue_data;
        w_pkt.synchronized = sq_dequeue_synchronized;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_pkt        <= '0;
      r_last_grant <= SRC_SQ;
    end else if (w_load) begin
      r_valid      <= 1'b1;
      r_pkt        <= w_pkt;
      r_last_grant <= w_src;
    end else if (l2_ready) begin
      r_valid      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_credits <= FULL;
    end else if (w_load && !l2_credit_return) begin
      r_credits <= r_credits - 1'b1;
    end else if (!w_load && l2_credit_return && r_credits != FULL) begin
      r_credits <= r_credits + 1'b1;
    end
  end

  assign l2_req_valid = r_valid;
  assign l2_req       = r_pkt;

  a_credit_overflow: assert property (@(posedge clk) disable iff (reset)
    !(l2_credit_return && r_credits == FULL));

  a_flush_sync: assert property (@(posedge clk) disable iff (reset)
    !(sq_dequeue_ready && sq_dequeue_flush && sq_dequeue_synchronized));

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Randomized bench for l2_request_arbiter against a behavioural model.
// Model tracks credits, last winner and the output register directly.
module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           icache_req_ready;
  logic [31:0]    icache_req_addr;
  logic [1:0]     icache_req_idx;
  logic           icache_req_ack;
  logic           dcache_req_ready;
  logic [31:0]    dcache_req_addr;
  logic [1:0]     dcache_req_idx;
  logic           dcache_req_ack;
  logic           sq_dequeue_ready;
  logic [31:0]    sq_dequeue_addr;
  logic [1:0]     sq_dequeue_idx;
  logic [63:0]    sq_dequeue_mask;
  logic [511:0]   sq_dequeue_data;
  logic           sq_dequeue_synchronized;
  logic           sq_dequeue_flush;
  logic           sq_dequeue_ack;
  logic           l2_req_valid;
  l2_req_packet_t l2_req;
  logic           l2_ready;
  logic           l2_credit_return;

  l2_request_arbiter #(.NUM_CREDITS(N)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .icache_req_ready        (icache_req_ready),
    .icache_req_addr         (icache_req_addr),
    .icache_req_idx          (icache_req_idx),
    .icache_req_ack          (icache_req_ack),
    .dcache_req_ready        (dcache_req_ready),
    .dcache_req_addr         (dcache_req_addr),
    .dcache_req_idx          (dcache_req_idx),
    .dcache_req_ack          (dcache_req_ack),
    .sq_dequeue_ready        (sq_dequeue_ready),
    .sq_dequeue_addr         (sq_dequeue_addr),
    .sq_dequeue_idx          (sq_dequeue_idx),
    .sq_dequeue_mask         (sq_dequeue_mask),
    .sq_dequeue_data         (sq_dequeue_data),
    .sq_dequeue_synchronized (sq_dequeue_synchronized),
    .sq_dequeue_flush        (sq_dequeue_flush),
    .sq_dequeue_ack          (sq_dequeue_ack),
    .l2_req_valid            (l2_req_valid),
    .l2_req                  (l2_req),
    .l2_ready                (l2_ready),
    .l2_credit_return        (l2_credit_return)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  int             m_credits;
  int             m_last;
  bit             m_valid;
  l2_req_packet_t m_pkt;
  bit             rand_fields = 1'b1;

  task automatic check(input string tag,
                       input logic [639:0] got,
                       input logic [639:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic l2_req_packet_t mk_pkt(input int src);
    l2_req_packet_t p;
    p = '0;
    p.source = 2'(src);
    if (src == 0) begin
      p.op   = L2_LOAD_INSN;
      p.idx  = icache_req_idx;
      p.addr = icache_req_addr;
    end else if (src == 1) begin
      p.op   = L2_LOAD;
      p.idx  = dcache_req_idx;
      p.addr = dcache_req_addr;
    end else begin
      p.op           = sq_dequeue_flush ? L2_FLUSH : L2_STORE;
      p.idx          = sq_dequeue_idx;
      p.addr         = sq_dequeue_addr;
      p.mask         = sq_dequeue_mask;
      p.data         = sq_dequeue_data;
      p.synchronized = sq_dequeue_synchronized;
    end
    return p;
  endfunction

  task automatic randomize_fields();
    int kind;
    icache_req_addr = {$urandom, 6'b0} ;
    icache_req_idx  = 2'($urandom);
    dcache_req_addr = {$urandom, 6'b0};
    dcache_req_idx  = 2'($urandom);
    sq_dequeue_addr = {$urandom, 6'b0};
    sq_dequeue_idx  = 2'($urandom);
    sq_dequeue_mask = {$urandom, $urandom};
    for (int w = 0; w < 16; w++)
      sq_dequeue_data[w*32 +: 32] = $urandom;
    kind = int'($urandom % 3);
    sq_dequeue_synchronized = (kind == 1);
    sq_dequeue_flush        = (kind == 2);
  endtask

  task automatic step(input bit ir, input bit dr, input bit sr,
                      input bit lr, input bit ret);
    bit [2:0]       rdy;
    bit             open;
    int             win;
    l2_req_packet_t exp_pkt;
    if (rand_fields) randomize_fields();
    icache_req_ready = ir;
    dcache_req_ready = dr;
    sq_dequeue_ready = sr;
    l2_ready         = lr;
    l2_credit_return = ret && (m_credits < N);
    rdy  = {sr, dr, ir};
    #1;
    open = (!m_valid || lr) && (m_credits != 0);
    win  = -1;
    if (open)
      for (int k = 1; k <= 3; k++)
        if (win < 0 && rdy[(m_last + k) % 3]) win = (m_last + k) % 3;
    check("ack_ic", icache_req_ack, win == 0);
    check("ack_dc", dcache_req_ack, win == 1);
    check("ack_sq", sq_dequeue_ack, win == 2);
    exp_pkt = (win >= 0) ? mk_pkt(win) : m_pkt;
    @(posedge clk);
    #1;
    if (win >= 0) begin
      m_valid = 1'b1;
      m_pkt   = exp_pkt;
      m_last  = win;
    end else if (lr) begin
      m_valid = 1'b0;
    end
    m_credits = m_credits - (win >= 0 ? 1 : 0) + (l2_credit_return ? 1 : 0);
    check("valid", l2_req_valid, m_valid);
    if (m_valid) check("pkt", l2_req, m_pkt);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    icache_req_ready = 1'b0;
    dcache_req_ready = 1'b0;
    sq_dequeue_ready = 1'b0;
    l2_ready         = 1'b0;
    l2_credit_return = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    m_credits = N;
    m_last    = 2;
    m_valid   = 1'b0;
    m_pkt     = '0;
    check("rst_valid", l2_req_valid, 1'b0);
    check("rst_pkt", l2_req, '0);
    check("rst_acks", {icache_req_ack, dcache_req_ack, sq_dequeue_ack}, 3'b000);
  endtask

  initial begin
    randomize_fields();
    do_reset();

    // single store
    rand_fields = 1'b0;
    sq_dequeue_addr         = 32'h1000;
    sq_dequeue_idx          = 2'd1;
    sq_dequeue_mask         = 64'hF;
    sq_dequeue_data         = '0;
    sq_dequeue_data[7:0]    = 8'hAB;
    sq_dequeue_synchronized = 1'b0;
    sq_dequeue_flush        = 1'b0;
    step(0, 0, 1, 1, 0);
    check("st_op", l2_req.op, L2_STORE);
    check("st_addr", l2_req.addr, 32'h1000);
    check("st_src", l2_req.source, 2'd2);
    rand_fields = 1'b1;

    // round robin with returns every cycle
    for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 1);

    // stall then drain with back-to-back issue
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 1);
    step(1, 1, 1, 1, 1);

    // credit exhaustion, then one return
    for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 0);
    check("exhaust", m_credits, 0);
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);

    // random traffic
    for (int i = 0; i < 1500; i++)
      step($urandom % 2 == 1, $urandom % 2 == 1, $urandom % 2 == 1,
           $urandom % 4 != 0, $urandom % 2 == 1);

    // reset mid-operation with one credit left
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0);
    do_reset();
    step(1, 1, 1, 1, 0);
    check("post_rst_src", l2_req.source, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
- Shares the core's single L2 request port between three requesters: instruction-cache miss queue, data-cache load miss queue and L1 store queue (stores, synchronized stores, flushes).
- Round-robin arbitration with an acknowledge back to the winner.
- Registers the winning request into an output stage held until L2 accepts it.
- Enforces a credit limit on outstanding L2 requests.

Parameters:
- NUM_CREDITS, default 4: maximum L2 requests outstanding (issued but not credit-returned); must be at least 1.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- icache_req_ready  in  1  icache miss queue has a request
- icache_req_addr  in  32  line-aligned address
- icache_req_idx  in  2  miss entry index
- icache_req_ack  out  1  icache request accepted this cycle
- dcache_req_ready  in  1  dcache load miss queue has a request
- dcache_req_addr  in  32  line-aligned address
- dcache_req_idx  in  2  miss entry index
- dcache_req_ack  out  1  dcache request accepted this cycle
- sq_dequeue_ready  in  1  store queue has a request
- sq_dequeue_addr  in  32  line-aligned address
- sq_dequeue_idx  in  2  store queue entry index
- sq_dequeue_mask  in  64  byte-enable mask
- sq_dequeue_data  in  512  store line data
- sq_dequeue_synchronized  in  1  synchronized store
- sq_dequeue_flush  in  1  flush request
- sq_dequeue_ack  out  1  store queue request accepted this cycle
- l2_req_valid  out  1  output register holds a request
- l2_req  out  l2_req_packet_t  registered request packet
- l2_ready  in  1  L2 accepts l2_req this cycle when l2_req_valid
- l2_credit_return  in  1  one outstanding request retired (one-cycle pulse)

Behaviour:
- Reset (synchronous, active-high): all outputs and state are cleared regardless of in-flight state.
  - l2_req_valid=0, l2_req=0, all acks=0.
  - credits=NUM_CREDITS; last_grant=2, so source 0 (icache) has first priority.
  - In-flight requests are forgotten; credit returns for them arriving after reset are not counted.
- Credit counter width: $clog2(NUM_CREDITS+1). Requesters are indexed 0=icache, 1=dcache, 2=store queue.
- Issue slot is open when: !l2_req_valid || l2_ready (empty, or draining this cycle), AND credits != 0.
- Arbitration (combinational, same cycle as the slot being open):
  - Among ready sources, grant the first found scanning from (last_grant+1) mod 3 upward.
  - Exactly that source's ack is asserted; acks are one-hot-or-zero.
  - An ack is never asserted when the slot is closed.
- Load: on grant, at the next clock edge:
  - l2_req_valid <= 1 and l2_req is loaded from the winner's fields.
  - last_grant <= winner.
  - Latency is one cycle from ack to l2_req_valid.
  - Back-to-back issue is possible: drain and load happen in the same cycle.
- Drain without a new grant: l2_req_valid <= 0 and l2_req holds its value (don't care).
- Stall: while l2_req_valid && !l2_ready, l2_req is held stable and no acks are asserted.
- Packet contents (l2_req):
  - op = L2_LOAD_INSN (src 0), L2_LOAD (src 1), L2_FLUSH (src 2 with flush), or L2_STORE (src 2 otherwise).
  - source = source id; idx, addr copied from the winner.
  - mask/data/synchronized copied from the store queue for src 2, zero otherwise.
  - flush and synchronized both set is a protocol error: assertion; op=L2_FLUSH.
- Credits:
  - Decrement on each load event; increment on l2_credit_return.
  - Both in the same cycle leave the count unchanged.
  - Return while credits==NUM_CREDITS: assertion failure, count saturates.
  - A return arriving while credits==0 reopens the slot only in the following cycle; the slot test uses the registered count.
- Fairness: a continuously-ready source is granted within 3 issue slots.

Decomposition:
- Shared package (defines.sv):
  - l2_op_t enum {L2_LOAD, L2_LOAD_INSN, L2_STORE, L2_FLUSH}.
  - l2_req_source_t (2 bits).
  - l2_req_packet_t {op, source, idx, synchronized, addr, mask, data}.
- Sub-module rr_arbiter3:
  - Rotating-priority one-hot grant from request[2:0] and last_grant.
  - Purely combinational, unit-testable alone.
- Credit counter and output register stay in the top module.

Test Plan:
- Single store: sq_dequeue_ready=1, addr=0x1000, mask=0xF, data=0xAB in byte 0, l2_ready=1.
  - sq_dequeue_ack=1 in cycle 0.
  - Cycle 1: l2_req_valid=1, op=L2_STORE, addr=0x1000, source=2, credits=3.
- Round robin: all three ready for 6 cycles, l2_ready=1, credits returned every cycle.
  - Grant order 0,1,2,0,1,2; exactly one ack per cycle.
- Stall: l2_ready=0 for 5 cycles with all sources ready.
  - l2_req held bit-stable and no acks during the stall.
  - On l2_ready=1, the next ack occurs in the same cycle as the drain.
- Credit exhaustion (NUM_CREDITS=4): 4 issues, then no acks with sources ready.
  - One credit_return pulse → exactly one ack the following cycle, then credits=0 again.
- Simultaneous issue and credit_return with credits=2: count stays 2.
- Reset mid-operation: l2_req_valid=1, credits=1; assert reset one cycle.
  - Next cycle: l2_req_valid=0, credits=4, acks=0.
  - The first grant after reset goes to icache when all sources are ready.
